tl_trace_buf: RTL and testbench
===============================

Name: tl_trace_buf

Overview:
Parametrised TileLink transaction tracer that passively snoops one A/D channel pair and records filtered beats into a circular trace buffer. The buffer is drained through a valid/ready readout port. It is the synthesizable successor of the RAM debug monitor: it adds an address window, an opcode filter, wrap or stop-on-full modes, timestamps, overflow accounting and an optional simulation echo. It sits beside any TileLink slave (RAM, ROM, MMIO) and drives nothing on the bus.

Parameters:
ADDR_W, 64, TileLink address width
DATA_W, 64, TileLink data width; a_mask is DATA_W/8 bits
DEPTH, 16, trace entries; power of 2, at least 4
TS_W, 16, timestamp width
VERBOSE, 0, when 1, simulation-only $display of every captured record

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
a_valid, a_ready  in  1 each  A-channel handshake (snooped)
a_opcode  in  3  A opcode
a_size  in  3  A size
a_address  in  ADDR_W  A address
a_mask  in  DATA_W/8  A byte mask
a_data  in  DATA_W  A data
d_valid, d_ready  in  1 each  D-channel handshake (snooped)
d_opcode  in  3  D opcode
d_data  in  DATA_W  D data
cap_en  in  1  capture enable
wrap_mode  in  1  1: overwrite oldest when full; 0: drop newest when full
clear  in  1  synchronous flush of buffer, counters and flags
win_lo, win_hi  in  ADDR_W each  inclusive capture address window
op_en  in  3  bit0 enables Get, bit1 enables PutFull, bit2 enables PutPartial
rd_valid  out  1  head entry available
rd_ready  in  1  pop head
rd_data  out  1+3+3+DATA_W/8+ADDR_W+DATA_W+TS_W  {kind, opcode, size, mask, addr, data, ts}; kind 0 = A, 1 = D
count  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky; set on any dropped or overwritten entry
dropped  out  16  saturating count of lost entries

Behaviour:
- Reset (rst_n = 0 at a clk edge): clears pointers, count, overflow, dropped, the outstanding counter and the timestamp counter. rd_valid = 0. rd_data contents are don't-care.
- clear: same effect as reset except the timestamp. Priority order is reset, then clear, then pop, then push.
- ts: free-running TS_W counter, wraps to 0. A record stores the ts value of its handshake cycle.
- A capture: a_valid & a_ready & cap_en & win_lo <= a_address <= win_hi & the op_en bit for a_opcode is set. Only Get=4, PutFull=0 and PutPartial=1 are eligible; other opcodes are never captured.
- Each A capture increments the outstanding counter (8 bits, saturating).
- D capture: d_valid & d_ready & outstanding != 0 & d_opcode in {AccessAck=0, AccessAckData=1}. Each D capture decrements outstanding.
- D beats are captured regardless of cap_en, so the request/response pairing stays consistent.
- Bus contract: responses are in-order, with one D beat per request.
- D records store addr = 0, mask = 0 and size = 0. Data is stored for AccessAck as well.
- Same-cycle A and D captures: the A record is written at wptr and the D record at wptr+1 (mod DEPTH).
- Same-cycle A and D capture with outstanding = 0: the D beat belongs to an earlier request and is not captured. The A record is captured and outstanding becomes 1.
- Timing: a record is visible on rd_valid/rd_data in the cycle after its handshake. rd_data is show-ahead from the array head.
- Pop: rd_valid & rd_ready advances head. A pop and a push in the same cycle are both honoured; the pop frees its slot before the push is evaluated.
- Full handling, wrap_mode = 1: each push beyond capacity advances head (oldest lost), sets overflow and increments dropped.
- Full handling, wrap_mode = 0: excess pushes are discarded, the newest first, which is the D record of a pair. Each discarded push sets overflow and increments dropped.
- dropped saturates at 16'hFFFF.
- count = wptr - rptr, within 0..DEPTH. rd_valid = (count != 0).
- Pointers are $clog2(DEPTH)+1 bits so that full and empty are distinguishable.
- The window test is unsigned. win_lo > win_hi means nothing is captured.
- VERBOSE: $display per record in the style "TRACE(A get): [addr]". This is excluded from synthesis.

Test Plan:
1. Reset, then Get at 0x8000_0000 with window 0x8000_0000..0x8000_FFFF and op_en = 3'b111. Next cycle: rd_valid = 1, kind 0, opcode 4, addr 0x8000_0000, count = 1.
2. Same-cycle AccessAckData d_data = 0xDEAD_BEEF (outstanding = 1) and PutFull at 0x8000_0010. Next cycle: count += 2; pop order is A(PutFull), then D (data 0xDEAD_BEEF).
3. Get at 0x9000_0000, or PutPartial with op_en = 3'b011. Nothing is captured and outstanding is unchanged. A later AccessAck with outstanding = 0 is also not captured.
4. DEPTH = 16, wrap_mode = 0, 18 Gets with no pops: count = 16, dropped = 2, overflow = 1, first pop returns ts of Get #1.
5. The same sequence with wrap_mode = 1: count = 16, dropped = 2, first pop is Get #3. Pop and push in the same full cycle leaves count = 16 with no further drop.
6. clear asserted mid-burst with rd_ready = 1: next cycle count = 0, rd_valid = 0, overflow = 0, dropped = 0. rst_n low for one cycle gives the same result, plus ts restarts at 0.

Source files
------------

// File: rtl/tl_trace_buf.sv
// Passive TileLink A/D snooper recording filtered beats into a circular trace buffer.
// Records are {kind, opcode, size, mask, addr, data, ts}, drained show-ahead through rd_valid/rd_ready.
module tl_trace_buf #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  parameter int TS_W    = 16,
  parameter bit VERBOSE = 0
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                a_valid,
  input  logic                                                a_ready,
  input  logic [2:0]                                          a_opcode,
  input  logic [2:0]                                          a_size,
  input  logic [ADDR_W-1:0]                                   a_address,
  input  logic [DATA_W/8-1:0]                                 a_mask,
  input  logic [DATA_W-1:0]                                   a_data,
  input  logic                                                d_valid,
  input  logic                                                d_ready,
  input  logic [2:0]                                          d_opcode,
  input  logic [DATA_W-1:0]                                   d_data,
  input  logic                                                cap_en,
  input  logic                                                wrap_mode,
  input  logic                                                clear,
  input  logic [ADDR_W-1:0]                                   win_lo,
  input  logic [ADDR_W-1:0]                                   win_hi,
  input  logic [2:0]                                          op_en,
  output logic                                                rd_valid,
  input  logic                                                rd_ready,
  output logic [1+3+3+DATA_W/8+ADDR_W+DATA_W+TS_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]                              count,
  output logic                                                overflow,
  output logic [15:0]                                         dropped
);
  localparam int MW    = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int REC_W = 1 + 3 + 3 + MW + ADDR_W + DATA_W + TS_W;
  localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;
  // op_en bit order: bit0 Get, bit1 PutFull, bit2 PutPartial
  localparam logic [8:0] ELIG_OPS = {OP_PUT_PARTIAL, OP_PUT_FULL, OP_GET};

  logic [REC_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     wptr_reg;
  logic [PW-1:0]     rptr_reg;
  logic [7:0]        outstanding_reg;
  logic [TS_W-1:0]   ts_reg;
  logic              overflow_reg;
  logic [15:0]       dropped_reg;

  logic [2:0]        op_hit;
  logic              in_win;
  logic              a_cap;
  logic              d_cap;
  logic [REC_W-1:0]  a_rec;
  logic [REC_W-1:0]  d_rec;
  logic [REC_W-1:0]  wr0_rec;
  logic              wr0_en;
  logic              wr1_en;
  logic [AW-1:0]     wr0_idx;
  logic [AW-1:0]     wr1_idx;
  logic [PW-1:0]     count_int;
  logic              pop;
  logic [PW:0]       held;
  logic [PW:0]       space;
  logic [PW:0]       total;
  logic [1:0]        n_push;
  logic [1:0]        n_acc;
  logic [1:0]        n_lost;
  logic [1:0]        n_evict;
  logic [16:0]       drop_sum;
  logic [15:0]       dropped_next;

  for (genvar gi = 0; gi < 3; gi++) begin : g_op
    assign op_hit[gi] = op_en[gi] && (a_opcode == ELIG_OPS[gi*3 +: 3]);
  end

  assign in_win = (a_address >= win_lo) && (a_address <= win_hi);
  assign a_cap  = a_valid && a_ready && cap_en && in_win && (op_hit != 3'b000);
  // D beats ignore cap_en so the request/response pairing never drifts
  assign d_cap  = d_valid && d_ready && (outstanding_reg != 8'd0) &&
                  ((d_opcode == OP_ACK) || (d_opcode == OP_ACK_DATA));

  assign a_rec = {1'b0, a_opcode, a_size, a_mask, a_address, a_data, ts_reg};
  assign d_rec = {1'b1, d_opcode, 3'b000, {MW{1'b0}}, {ADDR_W{1'b0}}, d_data, ts_reg};

  assign count_int = wptr_reg - rptr_reg;

  always_comb begin
    pop     = (count_int != '0) && rd_ready;
    n_push  = {1'b0, a_cap} + {1'b0, d_cap};
    held    = {1'b0, count_int} - (PW+1)'(pop);
    space   = DEPTH_P - held;
    total   = held + (PW+1)'(n_push);
    n_acc   = n_push;
    n_lost  = 2'd0;
    n_evict = 2'd0;
    if (!wrap_mode) begin
      // newest records are the ones discarded, so the D half of a pair goes first
      if (space < (PW+1)'(n_push)) begin
        n_acc  = space[1:0];
        n_lost = n_push - space[1:0];
      end
    end else if (total > DEPTH_P) begin
      n_lost  = 2'(total - DEPTH_P);
      n_evict = n_lost;
    end
    wr0_en       = (n_acc != 2'd0);
    wr1_en       = (n_acc == 2'd2);
    wr0_rec      = a_cap ? a_rec : d_rec;
    wr0_idx      = wptr_reg[AW-1:0];
    wr1_idx      = wptr_reg[AW-1:0] + AW'(1);
    drop_sum     = {1'b0, dropped_reg} + 17'(n_lost);
    dropped_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      outstanding_reg <= 8'd0;
      ts_reg          <= '0;
      overflow_reg    <= 1'b0;
      dropped_reg     <= 16'd0;
    end else begin
      ts_reg <= ts_reg + TS_W'(1);
      if (clear) begin
        wptr_reg        <= '0;
        rptr_reg        <= '0;
        outstanding_reg <= 8'd0;
        overflow_reg    <= 1'b0;
        dropped_reg     <= 16'd0;
      end else begin
        wptr_reg    <= wptr_reg + PW'(n_acc);
        rptr_reg    <= rptr_reg + PW'(pop) + PW'(n_evict);
        dropped_reg <= dropped_next;
        if (n_lost != 2'd0)
          overflow_reg <= 1'b1;
        if (a_cap && !d_cap && (outstanding_reg != 8'hFF))
          outstanding_reg <= outstanding_reg + 8'd1;
        else if (d_cap && !a_cap)
          outstanding_reg <= outstanding_reg - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear) begin
      if (wr0_en)
        mem[wr0_idx] <= wr0_rec;
      if (wr1_en)
        mem[wr1_idx] <= d_rec;
    end
  end

  assign rd_data  = mem[rptr_reg[AW-1:0]];
  assign rd_valid = (count_int != '0);
  assign count    = count_int;
  assign overflow = overflow_reg;
  assign dropped  = dropped_reg;

`ifndef SYNTHESIS
  if (VERBOSE) begin : g_verbose
    always_ff @(posedge clk) begin
      if (rst_n && !clear) begin
        if (a_cap) begin
          case (a_opcode)
            OP_GET:      $display("TRACE(A get): 0x%h", a_address);
            OP_PUT_FULL: $display("TRACE(A putfull): 0x%h", a_address);
            default:     $display("TRACE(A putpartial): 0x%h", a_address);
          endcase
        end
        if (d_cap)
          $display("TRACE(D %0s): 0x%h", (d_opcode == OP_ACK_DATA) ? "ackdata" : "ack", d_data);
      end
    end
  end
`endif

endmodule

// File: tb/tb_tl_trace_buf.sv
// Randomised and directed bench for tl_trace_buf against a queue-based reference model.
module tb_tl_trace_buf;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int MW     = DATA_W / 8;
  localparam int REC_W  = 1 + 3 + 3 + MW + ADDR_W + DATA_W + TS_W;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int KIND_B = REC_W - 1;
  localparam int OP_LSB = REC_W - 4;
  localparam int SZ_LSB = REC_W - 7;
  localparam int MK_LSB = ADDR_W + DATA_W + TS_W;
  localparam int AD_LSB = DATA_W + TS_W;
  localparam int DT_LSB = TS_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, a_valid, a_ready, d_valid, d_ready;
  logic [2:0]        a_opcode, a_size, d_opcode, op_en;
  logic [ADDR_W-1:0] a_address, win_lo, win_hi;
  logic [MW-1:0]     a_mask;
  logic [DATA_W-1:0] a_data, d_data;
  logic              cap_en, wrap_mode, clear, rd_ready;
  logic              rd_valid, overflow;
  logic [REC_W-1:0]  rd_data;
  logic [CW-1:0]     count;
  logic [15:0]       dropped;

  tl_trace_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .VERBOSE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_data(d_data),
    .cap_en(cap_en), .wrap_mode(wrap_mode), .clear(clear),
    .win_lo(win_lo), .win_hi(win_hi), .op_en(op_en),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .overflow(overflow), .dropped(dropped)
  );

  // reference model: a bounded queue of records plus plain integer bookkeeping
  logic [REC_W-1:0] mq[$];
  int m_out, m_drop, m_ts;
  bit m_ovf;
  int passed = 0;
  int total  = 0;

  function automatic void m_push(input logic [REC_W-1:0] r, input logic wrap);
    if (mq.size() < DEPTH) mq.push_back(r);
    else begin
      if (wrap) begin
        mq.delete(0);
        mq.push_back(r);
      end
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
  endfunction

  task automatic tick();
    logic [TS_W-1:0] cts;
    bit op_ok, a_hit, d_hit;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); m_out = 0; m_drop = 0; m_ovf = 0; m_ts = 0;
    end else begin
      cts  = TS_W'(m_ts);
      m_ts = (m_ts + 1) % (1 << TS_W);
      if (clear) begin
        mq.delete(); m_out = 0; m_drop = 0; m_ovf = 0;
      end else begin
        op_ok = (a_opcode == 3'd4 && op_en[0]) || (a_opcode == 3'd0 && op_en[1]) ||
                (a_opcode == 3'd1 && op_en[2]);
        a_hit = a_valid && a_ready && cap_en && op_ok && a_address >= win_lo && a_address <= win_hi;
        d_hit = d_valid && d_ready && m_out > 0 && (d_opcode == 3'd0 || d_opcode == 3'd1);
        if (rd_ready && mq.size() > 0) mq.delete(0);
        if (a_hit) m_push({1'b0, a_opcode, a_size, a_mask, a_address, a_data, cts}, wrap_mode);
        if (d_hit) m_push({1'b1, d_opcode, 3'b000, {MW{1'b0}}, {ADDR_W{1'b0}}, d_data, cts}, wrap_mode);
        if (a_hit && !d_hit && m_out < 255) m_out++;
        else if (d_hit && !a_hit) m_out--;
      end
    end
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_ready = 1; d_valid = 0; d_ready = 1; rd_ready = 0; clear = 0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [ADDR_W-1:0] addr);
    a_valid = 1; a_ready = 1; a_opcode = op; a_size = 3'd3; a_address = addr;
    a_mask = 8'hFF; a_data = {$urandom, $urandom};
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [DATA_W-1:0] data);
    d_valid = 1; d_ready = 1; d_opcode = op; d_data = data;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    a_opcode = 0; a_size = 0; a_address = 0; a_mask = 0; a_data = 0; d_opcode = 0; d_data = 0;
    win_lo = 64'h8000_0000; win_hi = 64'h8000_FFFF; op_en = 3'b111; cap_en = 1; wrap_mode = 0;
    do_reset();
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    total++; if (dropped !== 16'd0) $display("FAIL reset_dropped: got %0d want 0", dropped); else passed++;
  endtask

  task automatic test_get();
    drive_a(3'd4, 64'h8000_0000); tick(); idle();
    total++; if (rd_valid !== 1'b1) $display("FAIL get_rd_valid: got %b want 1", rd_valid); else passed++;
    total++; if (rd_data[KIND_B] !== 1'b0) $display("FAIL get_kind: got %b want 0", rd_data[KIND_B]); else passed++;
    total++; if (rd_data[OP_LSB +: 3] !== 3'd4) $display("FAIL get_opcode: got %0d want 4", rd_data[OP_LSB +: 3]); else passed++;
    total++; if (rd_data[AD_LSB +: ADDR_W] !== 64'h8000_0000) $display("FAIL get_addr: got %h want 80000000", rd_data[AD_LSB +: ADDR_W]); else passed++;
    total++; if (count !== CW'(1)) $display("FAIL get_count: got %0d want 1", count); else passed++;
    total++; if (rd_data[TS_W-1:0] !== 16'd0) $display("FAIL get_ts: got %0d want 0", rd_data[TS_W-1:0]); else passed++;
  endtask

  task automatic test_pair();
    drive_a(3'd0, 64'h8000_0010); drive_d(3'd1, 64'hDEAD_BEEF); tick(); idle();
    total++; if (count !== CW'(3)) $display("FAIL pair_count: got %0d want 3", count); else passed++;
    rd_ready = 1; tick();
    total++; if (rd_data[KIND_B] !== 1'b0 || rd_data[OP_LSB +: 3] !== 3'd0 || rd_data[AD_LSB +: ADDR_W] !== 64'h8000_0010)
      $display("FAIL pair_first_a: got %h want putfull at 80000010", rd_data); else passed++;
    tick();
    total++; if (rd_data[KIND_B] !== 1'b1 || rd_data[OP_LSB +: 3] !== 3'd1 || rd_data[DT_LSB +: DATA_W] !== 64'hDEAD_BEEF)
      $display("FAIL pair_second_d: got %h want ackdata deadbeef", rd_data); else passed++;
    total++; if (rd_data[AD_LSB +: ADDR_W] !== '0 || rd_data[MK_LSB +: MW] !== '0 || rd_data[SZ_LSB +: 3] !== 3'd0)
      $display("FAIL pair_d_zero_fields: got %h want addr/mask/size 0", rd_data); else passed++;
    total++; if (rd_data[TS_W-1:0] !== 16'd1) $display("FAIL pair_d_ts: got %0d want 1", rd_data[TS_W-1:0]); else passed++;
    tick(); rd_ready = 0;
    total++; if (count !== '0 || rd_valid !== 1'b0) $display("FAIL pair_drain: got count %0d want 0", count); else passed++;
  endtask

  task automatic test_filter();
    drive_d(3'd0, 64'h1234); tick(); idle();
    total++; if (count !== CW'(1)) $display("FAIL filt_ack_out1: got %0d want 1", count); else passed++;
    rd_ready = 1; tick(); idle();
    drive_a(3'd4, 64'h9000_0000); tick(); idle();
    total++; if (count !== '0) $display("FAIL filt_outside: got %0d want 0", count); else passed++;
    op_en = 3'b011; drive_a(3'd1, 64'h8000_0020); tick(); idle(); op_en = 3'b111;
    total++; if (count !== '0) $display("FAIL filt_putpartial_off: got %0d want 0", count); else passed++;
    drive_a(3'd2, 64'h8000_0020); tick(); idle();
    total++; if (count !== '0) $display("FAIL filt_bad_opcode: got %0d want 0", count); else passed++;
    cap_en = 0; drive_a(3'd4, 64'h8000_0020); tick(); idle(); cap_en = 1;
    total++; if (count !== '0) $display("FAIL filt_cap_en_off: got %0d want 0", count); else passed++;
    drive_d(3'd0, 64'h55); tick(); idle();
    total++; if (count !== '0) $display("FAIL filt_ack_out0: got %0d want 0", count); else passed++;
    drive_a(3'd4, 64'h8000_0000); tick();
    drive_a(3'd4, 64'h8000_FFFF); tick();
    drive_a(3'd4, 64'h8001_0000); tick();
    drive_a(3'd4, 64'h7FFF_FFFF); tick(); idle();
    total++; if (count !== CW'(2)) $display("FAIL filt_window_edges: got %0d want 2", count); else passed++;
    win_lo = 64'h8000_FFFF; win_hi = 64'h8000_0000;
    drive_a(3'd4, 64'h8000_8000); tick(); idle();
    win_lo = 64'h8000_0000; win_hi = 64'h8000_FFFF;
    total++; if (count !== CW'(2)) $display("FAIL filt_empty_window: got %0d want 2", count); else passed++;
    drive_d(3'd0, 64'h1); tick(); drive_d(3'd0, 64'h2); tick(); drive_d(3'd0, 64'h3); tick(); idle();
    total++; if (count !== CW'(4)) $display("FAIL filt_ack_pairing: got %0d want 4", count); else passed++;
  endtask

  task automatic test_stop_full();
    do_reset(); wrap_mode = 0;
    for (int i = 0; i < 18; i++) begin
      drive_a(3'd4, 64'h8000_0000 + 64'(i * 8)); tick();
    end
    idle();
    total++; if (count !== CW'(16)) $display("FAIL stop_count: got %0d want 16", count); else passed++;
    total++; if (dropped !== 16'd2) $display("FAIL stop_dropped: got %0d want 2", dropped); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL stop_overflow: got %b want 1", overflow); else passed++;
    total++; if (rd_data[TS_W-1:0] !== 16'd0) $display("FAIL stop_first_ts: got %0d want 0", rd_data[TS_W-1:0]); else passed++;
  endtask

  task automatic test_wrap_full();
    do_reset(); wrap_mode = 1;
    for (int i = 0; i < 18; i++) begin
      drive_a(3'd4, 64'h8000_0000 + 64'(i * 8)); tick();
    end
    idle();
    total++; if (count !== CW'(16)) $display("FAIL wrap_count: got %0d want 16", count); else passed++;
    total++; if (dropped !== 16'd2) $display("FAIL wrap_dropped: got %0d want 2", dropped); else passed++;
    total++; if (rd_data[TS_W-1:0] !== 16'd2 || rd_data[AD_LSB +: ADDR_W] !== 64'h8000_0010)
      $display("FAIL wrap_first_is_get3: got %h want ts 2 addr 80000010", rd_data); else passed++;
    drive_a(3'd4, 64'h8000_0100); rd_ready = 1; tick(); idle();
    total++; if (count !== CW'(16) || dropped !== 16'd2) $display("FAIL wrap_pop_push: got count %0d dropped %0d want 16 2", count, dropped); else passed++;
    total++; if (rd_data[TS_W-1:0] !== 16'd3) $display("FAIL wrap_head_after_pop: got %0d want 3", rd_data[TS_W-1:0]); else passed++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      drive_a(3'd4, 64'h8000_0200); rd_ready = 1; tick();
    end
    clear = 1; drive_a(3'd4, 64'h8000_0208); rd_ready = 1; tick(); idle();
    total++; if (count !== '0 || rd_valid !== 1'b0) $display("FAIL clear_empty: got count %0d valid %b want 0 0", count, rd_valid); else passed++;
    total++; if (overflow !== 1'b0 || dropped !== 16'd0) $display("FAIL clear_flags: got ovf %b dropped %0d want 0 0", overflow, dropped); else passed++;
    drive_a(3'd4, 64'h8000_0300); tick(); idle();
    total++; if (mq.size() != 1 || rd_data[TS_W-1:0] !== mq[0][TS_W-1:0] || rd_data[TS_W-1:0] === 16'd0)
      $display("FAIL clear_keeps_ts: got %0d want nonzero running ts", rd_data[TS_W-1:0]); else passed++;
    drive_a(3'd4, 64'h8000_0400); rst_n = 0; tick(); rst_n = 1; idle();
    total++; if (count !== '0 || rd_valid !== 1'b0) $display("FAIL rst_empty: got count %0d valid %b want 0 0", count, rd_valid); else passed++;
    total++; if (overflow !== 1'b0 || dropped !== 16'd0) $display("FAIL rst_flags: got ovf %b dropped %0d want 0 0", overflow, dropped); else passed++;
    drive_a(3'd4, 64'h8000_0500); tick(); idle();
    total++; if (rd_data[TS_W-1:0] !== 16'd0) $display("FAIL rst_ts_restart: got %0d want 0", rd_data[TS_W-1:0]); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) wrap_mode = $urandom_range(0, 1);
      rst_n     = ($urandom_range(0, 599) != 0);
      clear     = ($urandom_range(0, 199) == 0);
      a_valid   = $urandom_range(0, 1);
      a_ready   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2: a_opcode = 3'd4;
        3, 4, 5: a_opcode = 3'd0;
        6, 7:    a_opcode = 3'd1;
        default: a_opcode = 3'($urandom);
      endcase
      a_size    = 3'($urandom);
      a_mask    = 8'($urandom);
      a_data    = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       a_address = win_lo;
        1:       a_address = win_hi;
        2:       a_address = win_hi + 64'd1;
        3:       a_address = {$urandom, $urandom};
        default: a_address = win_lo + 64'($urandom_range(0, 16'hFFFF));
      endcase
      d_valid   = $urandom_range(0, 1);
      d_ready   = ($urandom_range(0, 3) != 0);
      d_opcode  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
      d_data    = {$urandom, $urandom};
      cap_en    = ($urandom_range(0, 9) != 0);
      op_en     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      rd_ready  = ((i / 250) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      tick();
      total++; if (count !== CW'(mq.size())) $display("FAIL rnd_count cyc %0d: got %0d want %0d", i, count, mq.size()); else passed++;
      total++; if (rd_valid !== (mq.size() != 0)) $display("FAIL rnd_rd_valid cyc %0d: got %b want %b", i, rd_valid, mq.size() != 0); else passed++;
      total++; if (overflow !== m_ovf) $display("FAIL rnd_overflow cyc %0d: got %b want %b", i, overflow, m_ovf); else passed++;
      total++; if (dropped !== 16'(m_drop)) $display("FAIL rnd_dropped cyc %0d: got %0d want %0d", i, dropped, m_drop); else passed++;
      if (mq.size() > 0) begin
        total++; if (rd_data !== mq[0]) $display("FAIL rnd_rd_data cyc %0d: got %h want %h", i, rd_data, mq[0]); else passed++;
      end
    end
    rst_n = 1; idle(); cap_en = 1; op_en = 3'b111;
  endtask

  task automatic test_saturate();
    do_reset(); wrap_mode = 0;
    drive_a(3'd4, 64'h8000_0000); tick();
    for (int i = 0; i < 32800; i++) begin
      drive_a(3'd4, 64'h8000_0040); drive_d(3'd1, 64'(i)); tick();
    end
    idle();
    total++; if (dropped !== 16'hFFFF) $display("FAIL sat_dropped: got %h want ffff", dropped); else passed++;
    total++; if (dropped !== 16'(m_drop) || count !== CW'(16)) $display("FAIL sat_model: got %0d/%0d want %0d/16", dropped, count, m_drop); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL sat_overflow: got %b want 1", overflow); else passed++;
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_get();
    test_pair();
    test_filter();
    test_stop_full();
    test_wrap_full();
    test_clear();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
